// File: rtl/ccip_mem_responder_pkg.sv
// rtl/ccip_mem_responder_pkg.sv - shared types and index helper for the CCI-P host memory responder
package ccip_mem_responder_pkg;

    localparam int CL_DATA_W    = 512;
    localparam int CCIP_MDATA_W = 16;

    typedef struct packed {
        logic [CL_DATA_W-1:0]    data;
        logic [CCIP_MDATA_W-1:0] mdata;
    } t_rd_entry;

    typedef struct packed {
        logic [CCIP_MDATA_W-1:0] mdata;
    } t_wr_entry;

    // Upper address bits are dropped so out-of-range lines alias into memory.
    function automatic logic [63:0] clIndex(input logic [63:0] addr, input int idx_w);
        return addr & ((64'd1 << idx_w) - 64'd1);
    endfunction

endpackage

// File: rtl/sync_fifo_w.sv
// rtl/sync_fifo_w.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo_w #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ccip_host_mem_responder.sv
// rtl/ccip_host_mem_responder.sv - fixed-latency CCI-P host memory model answering c0 reads and c1 writes
module ccip_host_mem_responder
    import ccip_mem_responder_pkg::*;
#(
    parameter int MEM_LINES     = 64,
    parameter int ADDR_W        = 42,
    parameter int MDATA_W       = CCIP_MDATA_W,
    parameter int RD_LATENCY    = 4,
    parameter int WR_LATENCY    = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int ALMFULL_SLACK = 2,
    localparam int IDX_W        = $clog2(MEM_LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c0_req_valid,
    input  logic [ADDR_W-1:0]    c0_req_addr,
    input  logic [MDATA_W-1:0]   c0_req_mdata,
    output logic                 c0_almfull,
    output logic                 c0_rsp_valid,
    output logic [511:0]         c0_rsp_data,
    output logic [MDATA_W-1:0]   c0_rsp_mdata,
    input  logic                 c0_rsp_stall,
    input  logic                 c1_req_valid,
    input  logic [ADDR_W-1:0]    c1_req_addr,
    input  logic [MDATA_W-1:0]   c1_req_mdata,
    input  logic [511:0]         c1_req_data,
    output logic                 c1_almfull,
    output logic                 c1_rsp_valid,
    output logic [MDATA_W-1:0]   c1_rsp_mdata,
    input  logic                 c1_rsp_stall,
    input  logic                 bd_wr_en,
    input  logic [IDX_W-1:0]     bd_addr,
    input  logic [511:0]         bd_wr_data,
    output logic [511:0]         bd_rd_data,
    output logic                 overflow_err,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = 16;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_AF  = OCC_W'(FIFO_DEPTH - ALMFULL_SLACK);

    logic [CL_DATA_W-1:0] mem [MEM_LINES];
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;

    logic                  rd_acc, rd_drop, rd_pop, rd_empty;
    logic [CNT_W-1:0]      rd_fifo_cnt;
    logic [OCC_W-1:0]      rd_occ, rd_occ_next;
    logic [RD_LATENCY-1:0] rd_pipe_v;
    t_rd_entry             rd_pipe_e [RD_LATENCY];
    t_rd_entry             rd_head;

    logic                  wr_acc, wr_drop, wr_pop, wr_empty;
    logic [CNT_W-1:0]      wr_fifo_cnt;
    logic [OCC_W-1:0]      wr_occ, wr_occ_next;
    logic [WR_LATENCY-1:0] wr_pipe_v;
    t_wr_entry             wr_pipe_e [WR_LATENCY];
    t_wr_entry             wr_head;

    assign rd_idx = IDX_W'(clIndex(64'(c0_req_addr), IDX_W));
    assign wr_idx = IDX_W'(clIndex(64'(c1_req_addr), IDX_W));

    // Occupancy counts in-flight pipeline entries so the FIFO can never be overrun.
    assign rd_occ      = OCC_W'(rd_fifo_cnt) + OCC_W'($countones(rd_pipe_v));
    assign wr_occ      = OCC_W'(wr_fifo_cnt) + OCC_W'($countones(wr_pipe_v));
    assign rd_acc      = reset && c0_req_valid && (rd_occ < OCC_MAX);
    assign wr_acc      = reset && c1_req_valid && (wr_occ < OCC_MAX);
    assign rd_drop     = reset && c0_req_valid && !(rd_occ < OCC_MAX);
    assign wr_drop     = reset && c1_req_valid && !(wr_occ < OCC_MAX);
    assign rd_pop      = reset && !rd_empty && !c0_rsp_stall;
    assign wr_pop      = reset && !wr_empty && !c1_rsp_stall;
    assign rd_occ_next = rd_occ + OCC_W'(rd_acc) - OCC_W'(rd_pop);
    assign wr_occ_next = wr_occ + OCC_W'(wr_acc) - OCC_W'(wr_pop);

    // A c1 write issued after a backdoor write in the same cycle overrides it.
    always_ff @(posedge clk) begin
        if (bd_wr_en) begin
            mem[bd_addr] <= bd_wr_data;
        end
        if (wr_acc) begin
            mem[wr_idx] <= c1_req_data;
        end
    end

    assign bd_rd_data = mem[bd_addr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pipe_v <= '0;
        end else begin
            rd_pipe_v[0] <= rd_acc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe_v[i] <= rd_pipe_v[i-1];
            end
        end
        rd_pipe_e[0] <= '{data: mem[rd_idx], mdata: c0_req_mdata};
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_e[i] <= rd_pipe_e[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_pipe_v <= '0;
        end else begin
            wr_pipe_v[0] <= wr_acc;
            for (int i = 1; i < WR_LATENCY; i++) begin
                wr_pipe_v[i] <= wr_pipe_v[i-1];
            end
        end
        wr_pipe_e[0] <= '{mdata: c1_req_mdata};
        for (int i = 1; i < WR_LATENCY; i++) begin
            wr_pipe_e[i] <= wr_pipe_e[i-1];
        end
    end

    sync_fifo_w #(
        .WIDTH ($bits(t_rd_entry)),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pipe_v[RD_LATENCY-1]),
        .push_data (rd_pipe_e[RD_LATENCY-1]),
        .pop       (rd_pop),
        .head      (rd_head),
        .empty     (rd_empty),
        .count     (rd_fifo_cnt)
    );

    sync_fifo_w #(
        .WIDTH ($bits(t_wr_entry)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_pipe_v[WR_LATENCY-1]),
        .push_data (wr_pipe_e[WR_LATENCY-1]),
        .pop       (wr_pop),
        .head      (wr_head),
        .empty     (wr_empty),
        .count     (wr_fifo_cnt)
    );

    // almfull tracks the occupancy that will hold after this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            c0_rsp_valid <= 1'b0;
            c1_rsp_valid <= 1'b0;
            c0_almfull   <= 1'b0;
            c1_almfull   <= 1'b0;
            overflow_err <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
        end else begin
            c0_rsp_valid <= rd_pop;
            c1_rsp_valid <= wr_pop;
            c0_almfull   <= (rd_occ_next >= OCC_AF);
            c1_almfull   <= (wr_occ_next >= OCC_AF);
            if (rd_drop || wr_drop) begin
                overflow_err <= 1'b1;
            end
            if (rd_acc) begin
                rd_count <= rd_count + 32'd1;
            end
            if (wr_acc) begin
                wr_count <= wr_count + 32'd1;
            end
        end
        if (rd_pop) begin
            c0_rsp_data  <= rd_head.data;
            c0_rsp_mdata <= rd_head.mdata;
        end
        if (wr_pop) begin
            c1_rsp_mdata <= wr_head.mdata;
        end
    end

endmodule
